// File: rtl/timer60_controller_if.sv
// Control/status bundle between the timer controller, the user inputs and the
// two cascaded decimal digit counters.
interface timer60_controller_if;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic       Mode;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic       CntReset_n;
  logic       HoldOnes;
  logic       HoldTens;
  logic       Direction;
  logic       Running;
  logic       Done;

  // The master side is the user panel plus the counter datapath; the slave is the controller.
  modport master (
    output Start, Stop, Clear, Mode, Tens, Ones,
    input  CntReset_n, HoldOnes, HoldTens, Direction, Running, Done
  );

  modport slave (
    input  Start, Stop, Clear, Mode, Tens, Ones,
    output CntReset_n, HoldOnes, HoldTens, Direction, Running, Done
  );
endinterface

// File: rtl/timer60_controller.sv
// Sequencing controller for the 60-second timer: resets and preloads the two
// digit counters, paces their steps from a prescaler and detects completion.
module timer60_controller #(
  parameter int TICK_DIV = 50000000,
  parameter int PW       = 26
) (
  input logic                 Clock,
  input logic                 Reset,
  timer60_controller_if.slave bus
);

  typedef enum logic [2:0] {CLEAR, PRELOAD, IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [1:0]    preload_cnt;
  logic          cnt_reset_n;
  logic          hold_ones;
  logic          hold_tens;
  logic          direction;
  logic          running;
  logic          done;

  logic go;
  logic wrap;
  logic boundary;
  logic terminal;

  assign go       = bus.Start && !bus.Stop;
  assign wrap     = (prescaler == LAST);
  assign boundary = direction ? (bus.Ones == 4'd0) : (bus.Ones == 4'd9);
  assign terminal = direction ? (bus.Tens == 4'd0 && bus.Ones == 4'd0)
                              : (bus.Tens == 4'd5 && bus.Ones == 4'd9);

  assign bus.CntReset_n = cnt_reset_n;
  assign bus.HoldOnes   = hold_ones;
  assign bus.HoldTens   = hold_tens;
  assign bus.Direction  = direction;
  assign bus.Running    = running;
  assign bus.Done       = done;

  // Holds are registered pulses: a low hold lasts exactly one cycle and the
  // counter steps on the edge that ends it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= CLEAR;
      prescaler   <= '0;
      preload_cnt <= '0;
      cnt_reset_n <= 1'b0;
      hold_ones   <= 1'b1;
      hold_tens   <= 1'b1;
      direction   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
    end else if (bus.Clear) begin
      state       <= CLEAR;
      preload_cnt <= '0;
      cnt_reset_n <= 1'b0;
      hold_ones   <= 1'b1;
      hold_tens   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          // Both digits sit at 9 here; down mode walks tens to 5, up mode wraps both to 0.
          direction   <= bus.Mode;
          cnt_reset_n <= 1'b1;
          hold_tens   <= 1'b0;
          hold_ones   <= bus.Mode;
          preload_cnt <= '0;
          state       <= PRELOAD;
        end

        PRELOAD: begin
          if (direction && preload_cnt != 2'd3) begin
            preload_cnt <= preload_cnt + 2'd1;
          end else begin
            hold_ones <= 1'b1;
            hold_tens <= 1'b1;
            state     <= IDLE;
          end
        end

        IDLE: begin
          if (go) begin
            prescaler <= '0;
            running   <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          if (bus.Stop) begin
            // A wrap due this cycle is deferred so it fires right after resume.
            if (!wrap) prescaler <= prescaler + PW'(1);
            hold_ones <= 1'b1;
            hold_tens <= 1'b1;
            running   <= 1'b0;
            state     <= PAUSE;
          end else if (hold_ones && terminal) begin
            hold_ones <= 1'b1;
            hold_tens <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (wrap) begin
            prescaler <= '0;
            hold_ones <= 1'b0;
            hold_tens <= !boundary;
          end else begin
            prescaler <= prescaler + PW'(1);
            hold_ones <= 1'b1;
            hold_tens <= 1'b1;
          end
        end

        PAUSE: begin
          if (go) begin
            running <= 1'b1;
            state   <= RUN;
          end
        end

        DONE: begin
          done <= 1'b1;
        end

        default: begin
          state       <= CLEAR;
          cnt_reset_n <= 1'b0;
          hold_ones   <= 1'b1;
          hold_tens   <= 1'b1;
          running     <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/timer60_controller.md
Name: timer60_controller

Overview:
- Sequencing controller for the 60-second timer datapath: two cascaded decimal digit counters (ones and tens), each with Hold, Direction and active-low asynchronous reset.
- Reset forces a counter to 9.
- Owns the digit counters' reset, preloads them to the start value, generates the 1 Hz step pulses, cascades ones into tens, and detects timer completion.
- Sits between the user buttons/mode switch and the two counter instances.

Parameters:
- TICK_DIV, 50000000: clock cycles per timer step. Minimum 3.
- PW, 26: prescaler width. Must satisfy 2^PW >= TICK_DIV.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; start or resume counting.
- Stop  in  1  level; pause counting.
- Clear  in  1  level; restart the preload sequence.
- Mode  in  1  0 = count up 00->59, 1 = count down 59->00. Sampled only in CLEAR.
- Tens  in  4  tens digit from the tens counter.
- Ones  in  4  ones digit from the ones counter.
- CntReset_n  out  1  active-low reset to both counters.
- HoldOnes  out  1  hold to the ones counter; 0 = step this edge.
- HoldTens  out  1  hold to the tens counter.
- Direction  out  1  direction to both counters; equals the latched Mode.
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.

Behaviour:
- All outputs are registered.
- Reset (async) values:
  - state = CLEAR, CntReset_n = 0, HoldOnes = HoldTens = 1.
  - Direction = 1, Running = 0, Done = 0.
  - Prescaler = 0, preload count = 0.
- States:
  - CLEAR
    - Entered for exactly 1 cycle; CntReset_n = 0, so both digits become 9.
    - Latches Mode into Direction.
    - Goes to PRELOAD.
  - PRELOAD
    - Down (Direction = 1): 4 consecutive cycles with HoldTens = 0 and HoldOnes = 1, taking the digits 99 -> 59.
    - Up (Direction = 0): 1 cycle with HoldTens = HoldOnes = 0, taking the digits 99 -> 00.
    - Then goes to IDLE with both holds = 1.
  - IDLE: holds = 1.
    - Start -> RUN, prescaler cleared to 0.
  - RUN: Running = 1; the prescaler increments each cycle.
    - When the prescaler reaches TICK_DIV-1 it wraps to 0 and raises a step.
    - Step: the next cycle has HoldOnes = 0.
    - HoldTens = 0 in the same cycle only if the ones digit is at its boundary: Ones == 0 for down, Ones == 9 for up.
    - Step pulses are exactly 1 cycle.
    - Stop -> PAUSE.
    - Terminal check is evaluated only in cycles where no step pulse is in flight: down Tens == 0 and Ones == 0; up Tens == 5 and Ones == 9.
    - Terminal -> DONE next cycle; no further steps are issued.
  - PAUSE: holds = 1; the prescaler is frozen (not cleared).
    - Start -> RUN, resuming the prescaler count.
  - DONE: Done = 1, holds = 1.
    - Start and Stop are ignored; only Clear or Reset leave DONE.
- Priority:
  - Reset > Clear > Stop > Start.
  - Clear in any state, including mid-PRELOAD, -> CLEAR next cycle.
  - Start and Stop together in RUN -> PAUSE; in IDLE or PAUSE -> no change.
- Mode changes outside CLEAR have no effect on Direction.
- The Tens and Ones inputs are used only for the boundary and terminal checks. The controller never writes digit values except through the holds and reset.
- Reset mid-step: all holds return to 1 immediately (async) and the sequence restarts from CLEAR.
- Step latency: a prescaler wrap at cycle N gives a hold low during cycle N+1, and the digit changes at the end of N+1.

Test Plan:
1. Reset release, Mode = 1, TICK_DIV = 4 -> CntReset_n low for 1 cycle, then 4 HoldTens-only pulses; the counter model reads 59 and the block enters IDLE with Done = 0 and Running = 0.
2. Start held, down mode -> one HoldOnes pulse every 4 cycles; the digits go 59, 58 … 50, 49 (the tens pulse coincides with Ones == 0) … 00; then Done = 1, Running = 0 and no further pulses for 20 cycles.
3. Mode = 0 plus Clear -> a single dual pulse gives 00. Run to 59 -> Done. Check the tens pulse at 09 -> 10 and at 49 -> 50.
4. Stop mid-run at prescaler = 2, wait 10 cycles, then Start -> the first step occurs exactly 1 cycle after resume (the prescaler was preserved); the digits are unchanged during the pause.
5. Start and Stop together in RUN -> PAUSE. Clear during PRELOAD cycle 2 -> CLEAR, then a full 4-pulse preload ending at 59.
6. Async Reset asserted mid-pulse (HoldOnes = 0) -> HoldOnes = 1 and CntReset_n = 0 within the same cycle, with no clock edge required.
